// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the stalling data-memory responder.
package mem_resp_pkg;

  localparam int CNT_W           = 4;
  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_array.sv
// 2^ADDR_W x 16 word storage: synchronous write port, registered read port.
// The read register can be cleared so a faulted read reports zero.
module mem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [2**ADDR_W];
  logic [15:0] rdata_q;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata_q <= '0;
    else if (clr_i) rdata_q <= '0;
    else if (re_i)  rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stall_responder.sv
// Multi-cycle data-memory responder: accepts one request, stalls for LATENCY
// cycles, then pulses done (with err for odd addresses) and completes the access.
module mem_stall_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        enable,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err,
  output state_e      state_dbg_o
);

  // Handshake: a request is accepted on a rising edge where enable=1 and
  // stall=0; enable while stall=1 is dropped, and done/err pulse for exactly
  // one cycle, in which the responder is already idle and can accept again.

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                odd_q, odd_d;
  logic                wr_q, wr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_we, mem_re, mem_clr;

  // Address bits above the word index alias by design.
  logic                addr_hi_unused;
  assign addr_hi_unused = ^addr[15:ADDR_W+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      odd_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      odd_q   <= odd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    odd_d   = odd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    mem_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          idx_d   = addr[ADDR_W:1];
          odd_d   = addr[0];
          wr_d    = wr;
          wdata_d = data_in;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Completion edge: the array port fires together with done.
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = odd_q;
          mem_we  = wr_q & ~odd_q;
          mem_re  = ~wr_q & ~odd_q;
          mem_clr = ~wr_q & odd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .clr_i   (mem_clr),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (data_out)
  );

  assign stall       = (state_q == BUSY);
  assign done        = done_q;
  assign err         = err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mem_stall_responder.sv
// Drives a LATENCY=4 and a LATENCY=1 responder with identical stimulus and
// compares both against a transaction-level model every cycle.
module tb_mem_stall_responder;
  import mem_resp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] addr, data_in;
  logic        enable, wr;
  logic [15:0] dout_a, dout_b;
  logic        stall_a, stall_b, done_a, done_b, err_a, err_b;
  state_e      st_a, st_b;

  mem_stall_responder #(.ADDR_W(8), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .enable(enable), .wr(wr),
    .data_out(dout_a), .stall(stall_a), .done(done_a), .err(err_a), .state_dbg_o(st_a));

  mem_stall_responder #(.ADDR_W(8), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .enable(enable), .wr(wr),
    .data_out(dout_b), .stall(stall_b), .done(done_b), .err(err_b), .state_dbg_o(st_b));

  logic [15:0] dout_v[2];
  logic        stall_v[2], done_v[2], err_v[2], stbusy_v[2];
  assign dout_v[0]  = dout_a;   assign dout_v[1]  = dout_b;
  assign stall_v[0] = stall_a;  assign stall_v[1] = stall_b;
  assign done_v[0]  = done_a;   assign done_v[1]  = done_b;
  assign err_v[0]   = err_a;    assign err_v[1]   = err_b;
  assign stbusy_v[0] = (st_a == BUSY);
  assign stbusy_v[1] = (st_b == BUSY);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // A request accepted at edge t completes at edge t+latency; a completion
  // edge never accepts, so the next request lands on the following edge.
  int          lat_m[2] = '{4, 1};
  bit          busy_m[2];
  int          fin_m[2];
  bit          wr_m[2], odd_m[2];
  logic [7:0]  idx_m[2];
  logic [15:0] wd_m[2];
  logic [15:0] mem_m[2][256];
  logic [15:0] e_dout[2];
  bit          e_done[2], e_err[2];
  int          edge_n = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_m[k] = 1'b0; e_dout[k] = '0; e_done[k] = 1'b0; e_err[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      e_done[k] = 1'b0;
      e_err[k]  = 1'b0;
      if (busy_m[k]) begin
        if (edge_n == fin_m[k]) begin
          busy_m[k] = 1'b0;
          e_done[k] = 1'b1;
          e_err[k]  = odd_m[k];
          if (!odd_m[k]) begin
            if (wr_m[k]) mem_m[k][idx_m[k]] = wd_m[k];
            else         e_dout[k] = mem_m[k][idx_m[k]];
          end else if (!wr_m[k]) begin
            e_dout[k] = '0;
          end
        end
      end else if (enable) begin
        busy_m[k] = 1'b1;
        fin_m[k]  = edge_n + lat_m[k];
        wr_m[k]   = wr;
        odd_m[k]  = addr[0];
        idx_m[k]  = addr[8:1];
        wd_m[k]   = data_in;
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d_stall", k), {15'b0, stall_v[k]},  {15'b0, busy_m[k]});
      check($sformatf("dut%0d_state", k), {15'b0, stbusy_v[k]}, {15'b0, busy_m[k]});
      check($sformatf("dut%0d_done", k),  {15'b0, done_v[k]},   {15'b0, e_done[k]});
      check($sformatf("dut%0d_err", k),   {15'b0, err_v[k]},    {15'b0, e_err[k]});
      check($sformatf("dut%0d_dout", k),  dout_v[k],            e_dout[k]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit en, input bit w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    check_outputs();
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    model_edge();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (busy_m[0] || busy_m[1]); i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    check("drain_timeout", {15'b0, busy_m[0] | busy_m[1]}, 16'h0);
  endtask

  task automatic issue(input bit w, input logic [15:0] a, input logic [15:0] d);
    step(1'b1, w, a, d);
    drain();
  endtask

  task automatic reset_now();
    @(negedge clk);
    check_outputs();
    enable = 1'b0;
    rst    = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d_rst_stall", k), {15'b0, stall_v[k]}, 16'h0);
      check($sformatf("dut%0d_rst_done", k),  {15'b0, done_v[k]},  16'h0);
      check($sformatf("dut%0d_rst_err", k),   {15'b0, err_v[k]},   16'h0);
      check($sformatf("dut%0d_rst_dout", k),  dout_v[k],           16'h0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) mem_m[k][i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();

    // Preload every word the test touches with zero.
    for (int i = 0; i <= 40; i++) issue(1'b1, 16'(i << 1), 16'h0000);

    // Reset two cycles into an in-flight write; the write must not land.
    step(1'b1, 1'b1, 16'h0010, 16'h1234);
    step(1'b0, 1'b0, 16'h0, 16'h0);
    reset_now();
    issue(1'b0, 16'h0010, 16'h0);

    // Basic write then read.
    issue(1'b1, 16'h0020, 16'hBEEF);
    issue(1'b0, 16'h0020, 16'h0);

    // Enable held high: alternating write/read, one request per two cycles.
    step(1'b1, 1'b1, 16'h0002, 16'h1111);
    step(1'b1, 1'b1, 16'h0002, 16'h1111);
    step(1'b1, 1'b0, 16'h0002, 16'h0);
    step(1'b1, 1'b0, 16'h0002, 16'h0);
    step(1'b1, 1'b1, 16'h0002, 16'h2222);
    step(1'b1, 1'b1, 16'h0002, 16'h2222);
    step(1'b1, 1'b0, 16'h0002, 16'h0);
    step(1'b1, 1'b0, 16'h0002, 16'h0);
    drain();

    // Unaligned read and write.
    issue(1'b0, 16'h0031, 16'h0);
    issue(1'b1, 16'h0033, 16'hFFFF);
    issue(1'b0, 16'h0032, 16'h0);

    // Enable pulsed while a read is in flight.
    step(1'b1, 1'b0, 16'h0040, 16'h0);
    step(1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b1, 16'h0040, 16'h5555);
    drain();
    issue(1'b0, 16'h0040, 16'h0);

    // Upper address bits alias.
    issue(1'b1, 16'h0204, 16'hA5A5);
    issue(1'b0, 16'h0004, 16'h0);

    // Random traffic over the preloaded words.
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      a = {7'($urandom), 8'($urandom_range(0, 40)), 1'($urandom_range(0, 3) == 0)};
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    drain();
    step(1'b0, 1'b0, 16'h0, 16'h0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
